ps2_key_event_ctrl: RTL and testbench

//  Front-end controller for the PS/2 keyboard port. Oversamples ps2_clk/ps2_data in the system

---
 rtl/ps2_key_event_ctrl_pkg.sv | 27 ++
 rtl/ps2_evt_fifo.sv | 56 +++++
 rtl/ps2_key_event_ctrl.sv | 209 ++++++++++++++++++++
 tb/tb_ps2_key_event_ctrl.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_key_event_ctrl_pkg.sv
// Shared PS/2 definitions: frame FSM encodings, prefix/overrun codes and the key event payload.
package ps2_key_event_ctrl_pkg;

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_DATA   = 2'd1;
   localparam logic [1:0] ST_PARITY = 2'd2;
   localparam logic [1:0] ST_STOP   = 2'd3;

   localparam logic [7:0] PS2_PFX_EXT = 8'hE0;
   localparam logic [7:0] PS2_PFX_BRK = 8'hF0;
   localparam logic [7:0] PS2_OVR0    = 8'h00;
   localparam logic [7:0] PS2_OVR1    = 8'hFF;

   localparam int unsigned PS2_EVT_W = 10;

   typedef struct packed {
      logic       ext;
      logic       brk;
      logic [7:0] code;
   } ps2_evt_t;

   // PS/2 uses odd parity over the eight data bits plus the parity bit.
   function automatic logic ps2_parity_ok(input logic [7:0] data, input logic par);
      return (^data) ^ par;
   endfunction

endpackage

// File: rtl/ps2_evt_fifo.sv
// Show-ahead synchronous FIFO for key events; a push into a full FIFO is accepted only alongside a pop.
module ps2_evt_fifo
   import ps2_key_event_ctrl_pkg::*;
#(
   parameter int unsigned WIDTH = PS2_EVT_W,
   parameter int unsigned DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wr_en,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             rd_en,
   output logic [WIDTH-1:0] rd_data,
   output logic             full,
   output logic             empty
);

   localparam int unsigned AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      count;
   logic [AW:0]      count_nxt;
   logic             do_wr;
   logic             do_rd;

   always_comb begin
      do_rd     = rd_en && !empty;
      do_wr     = wr_en && (!full || do_rd);
      count_nxt = count + (AW+1)'(do_wr) - (AW+1)'(do_rd);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         full   <= 1'b0;
         empty  <= 1'b1;
      end else begin
         if (do_wr) begin
            mem[wr_ptr] <= wr_data;
            wr_ptr      <= wr_ptr + AW'(1);
         end
         if (do_rd) rd_ptr <= rd_ptr + AW'(1);
         count <= count_nxt;
         full  <= (count_nxt == (AW+1)'(DEPTH));
         empty <= (count_nxt == '0);
      end
   end

   assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/ps2_key_event_ctrl.sv
// PS/2 keyboard front end: sync/filter the port, frame 11-bit packets, fold E0/F0 prefixes into
// key events and queue them for the command decoder.
module ps2_key_event_ctrl
   import ps2_key_event_ctrl_pkg::*;
#(
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned FILT_LEN    = 4,
   parameter int unsigned TIMEOUT_CYC = 100000,
   parameter int unsigned FIFO_DEPTH  = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   input  logic       evt_ready,
   output logic       evt_valid,
   output logic [7:0] evt_code,
   output logic       evt_ext,
   output logic       evt_break,
   output logic       err_parity,
   output logic       err_frame,
   output logic       fifo_ovf,
   output logic       busy
);

   localparam int unsigned FCNT_W = $clog2(FILT_LEN + 1);
   localparam int unsigned TMO_W  = $clog2(TIMEOUT_CYC);

   logic [SYNC_STAGES-1:0] clk_sync;
   logic [SYNC_STAGES-1:0] data_sync;
   logic                   clk_s;
   logic                   data_s;
   logic                   filt_q;
   logic                   filt_prev_q;
   logic [FCNT_W-1:0]      filt_cnt;
   logic                   strobe_c;

   logic [1:0]       state_q,   state_d;
   logic [7:0]       byte_q,    byte_d;
   logic [2:0]       bit_cnt_q, bit_cnt_d;
   logic             par_q,     par_d;
   logic [TMO_W-1:0] tmo_q,     tmo_d;
   logic             err_parity_d;
   logic             err_frame_d;
   logic             byte_ok_q, byte_ok_d;
   logic             tmo_hit_c;

   logic             ext_q;
   logic             brk_q;
   logic             push_c;
   logic             pop_c;
   ps2_evt_t         evt_in;
   ps2_evt_t         evt_head;
   logic             fifo_full;
   logic             fifo_empty;

   assign clk_s  = clk_sync[SYNC_STAGES-1];
   assign data_s = data_sync[SYNC_STAGES-1];

   // Lines idle high, so sync and filter reset to 1 to avoid a phantom falling edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         clk_sync    <= '1;
         data_sync   <= '1;
         filt_q      <= 1'b1;
         filt_prev_q <= 1'b1;
         filt_cnt    <= '0;
      end else begin
         clk_sync    <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
         data_sync   <= {data_sync[SYNC_STAGES-2:0], ps2_data};
         filt_prev_q <= filt_q;
         if (clk_s != filt_q) begin
            if (filt_cnt == FCNT_W'(FILT_LEN - 1)) begin
               filt_q   <= clk_s;
               filt_cnt <= '0;
            end else begin
               filt_cnt <= filt_cnt + FCNT_W'(1);
            end
         end else begin
            filt_cnt <= '0;
         end
      end
   end

   assign strobe_c = filt_prev_q & ~filt_q;

   // Frame FSM next-state; the timeout only fires on cycles without a strobe.
   always_comb begin
      state_d      = state_q;
      byte_d       = byte_q;
      bit_cnt_d    = bit_cnt_q;
      par_d        = par_q;
      tmo_d        = (state_q == ST_IDLE) ? '0 : tmo_q + TMO_W'(1);
      err_parity_d = 1'b0;
      err_frame_d  = 1'b0;
      byte_ok_d    = 1'b0;
      tmo_hit_c    = 1'b0;
      if (strobe_c) begin
         tmo_d = '0;
         case (state_q)
            ST_IDLE: begin
               if (!data_s) begin
                  state_d   = ST_DATA;
                  bit_cnt_d = 3'd0;
               end else begin
                  err_frame_d = 1'b1;
               end
            end
            ST_DATA: begin
               byte_d = {data_s, byte_q[7:1]};
               if (bit_cnt_q == 3'd7) state_d = ST_PARITY;
               else                   bit_cnt_d = bit_cnt_q + 3'd1;
            end
            ST_PARITY: begin
               par_d   = data_s;
               state_d = ST_STOP;
            end
            ST_STOP: begin
               state_d = ST_IDLE;
               if (!data_s)                         err_frame_d  = 1'b1;
               else if (!ps2_parity_ok(byte_q, par_q)) err_parity_d = 1'b1;
               else                                 byte_ok_d    = 1'b1;
            end
            default: state_d = ST_IDLE;
         endcase
      end else if (state_q != ST_IDLE && tmo_q == TMO_W'(TIMEOUT_CYC - 1)) begin
         state_d     = ST_IDLE;
         tmo_d       = '0;
         err_frame_d = 1'b1;
         tmo_hit_c   = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         byte_q     <= '0;
         bit_cnt_q  <= '0;
         par_q      <= 1'b0;
         tmo_q      <= '0;
         err_parity <= 1'b0;
         err_frame  <= 1'b0;
         byte_ok_q  <= 1'b0;
         busy       <= 1'b0;
      end else begin
         state_q    <= state_d;
         byte_q     <= byte_d;
         bit_cnt_q  <= bit_cnt_d;
         par_q      <= par_d;
         tmo_q      <= tmo_d;
         err_parity <= err_parity_d;
         err_frame  <= err_frame_d;
         byte_ok_q  <= byte_ok_d;
         busy       <= (state_d != ST_IDLE);
      end
   end

   // Prefix folding; byte_q is stable during the byte_ok cycle since no strobe can follow that fast.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ext_q <= 1'b0;
         brk_q <= 1'b0;
      end else if (tmo_hit_c) begin
         ext_q <= 1'b0;
         brk_q <= 1'b0;
      end else if (byte_ok_q) begin
         case (byte_q)
            PS2_PFX_EXT: ext_q <= 1'b1;
            PS2_PFX_BRK: brk_q <= 1'b1;
            default: begin
               ext_q <= 1'b0;
               brk_q <= 1'b0;
            end
         endcase
      end
   end

   always_comb begin
      push_c = byte_ok_q && byte_q != PS2_PFX_EXT && byte_q != PS2_PFX_BRK &&
               byte_q != PS2_OVR0 && byte_q != PS2_OVR1;
      pop_c  = evt_valid && evt_ready;
      evt_in = '{ext: ext_q, brk: brk_q, code: byte_q};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) fifo_ovf <= 1'b0;
      else     fifo_ovf <= push_c && fifo_full && !pop_c;
   end

   ps2_evt_fifo #(
      .WIDTH (PS2_EVT_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (push_c),
      .wr_data (evt_in),
      .rd_en   (pop_c),
      .rd_data (evt_head),
      .full    (fifo_full),
      .empty   (fifo_empty)
   );

   assign evt_valid = !fifo_empty;
   assign evt_code  = evt_head.code;
   assign evt_ext   = evt_head.ext;
   assign evt_break = evt_head.brk;

endmodule

// File: tb/tb_ps2_key_event_ctrl.sv
// Directed bench for ps2_key_event_ctrl with an event scoreboard checked by a negedge monitor.
module tb_ps2_key_event_ctrl;
   import ps2_key_event_ctrl_pkg::*;

   localparam int unsigned TMO  = 500;
   localparam int unsigned HALF = 10;

   logic       clk = 1'b0;
   logic       rst;
   logic       ps2_clk;
   logic       ps2_data;
   logic       evt_ready;
   logic       evt_valid;
   logic [7:0] evt_code;
   logic       evt_ext;
   logic       evt_break;
   logic       err_parity;
   logic       err_frame;
   logic       fifo_ovf;
   logic       busy;

   int checks = 0;
   int errors = 0;
   int n_par  = 0;
   int n_frm  = 0;
   int n_ovf  = 0;
   int n_evt  = 0;
   ps2_evt_t exp_q[$];

   always #5 clk = ~clk;

   ps2_key_event_ctrl #(
      .SYNC_STAGES (2),
      .FILT_LEN    (4),
      .TIMEOUT_CYC (TMO),
      .FIFO_DEPTH  (4)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .ps2_clk    (ps2_clk),
      .ps2_data   (ps2_data),
      .evt_ready  (evt_ready),
      .evt_valid  (evt_valid),
      .evt_code   (evt_code),
      .evt_ext    (evt_ext),
      .evt_break  (evt_break),
      .err_parity (err_parity),
      .err_frame  (err_frame),
      .fifo_ovf   (fifo_ovf),
      .busy       (busy)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // One PS/2 bit; glitch adds a 2-cycle low pulse on ps2_clk inside the high phase.
   task automatic ps2_bit(input logic b, input logic glitch);
      ps2_data = b;
      if (glitch) begin
         tick(4);
         ps2_clk = 1'b0;
         tick(2);
         ps2_clk = 1'b1;
         tick(int'(HALF) - 6);
      end else begin
         tick(int'(HALF));
      end
      ps2_clk = 1'b0;
      tick(int'(HALF));
      ps2_clk = 1'b1;
   endtask

   task automatic send_frame(input logic [7:0] b, input logic par_flip, input logic stop,
                             input int glitch_at);
      ps2_bit(1'b0, 1'b0);
      for (int i = 0; i < 8; i++) ps2_bit(b[i], i == glitch_at);
      ps2_bit((~^b) ^ par_flip, 1'b0);
      ps2_bit(stop, 1'b0);
      ps2_data = 1'b1;
      tick(int'(HALF));
   endtask

   task automatic push_exp(input logic ext, input logic brk, input logic [7:0] code);
      ps2_evt_t e;
      e = '{ext: ext, brk: brk, code: code};
      exp_q.push_back(e);
   endtask

   task automatic drain(input int budget);
      for (int i = 0; i < budget && exp_q.size() != 0; i++) tick(1);
      check("drain_empty", 32'(exp_q.size()), 32'd0);
   endtask

   // Monitor: counts error pulses and pops the scoreboard on every accepted event.
   always @(negedge clk) begin
      if (!rst) begin
         if (err_parity) n_par++;
         if (err_frame)  n_frm++;
         if (fifo_ovf)   n_ovf++;
         if (evt_valid && evt_ready) begin
            n_evt++;
            checks++;
            assert (exp_q.size() != 0)
            else begin
               errors++;
               $error("FAIL evt_unexpected: observed %0h expected none",
                      {evt_ext, evt_break, evt_code});
            end
            if (exp_q.size() != 0) begin
               ps2_evt_t e;
               e = exp_q.pop_front();
               check("evt", 32'({evt_ext, evt_break, evt_code}), 32'(e));
            end
         end
      end
   end

   initial begin
      #2ms;
      $display("FAIL watchdog: observed no finish expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int b;
      rst       = 1'b1;
      ps2_clk   = 1'b1;
      ps2_data  = 1'b1;
      evt_ready = 1'b1;
      tick(5);
      check("rst_valid", 32'(evt_valid), 32'd0);
      check("rst_code",  32'(evt_code),  32'd0);
      check("rst_ext",   32'(evt_ext),   32'd0);
      check("rst_break", 32'(evt_break), 32'd0);
      check("rst_errp",  32'(err_parity), 32'd0);
      check("rst_errf",  32'(err_frame), 32'd0);
      check("rst_ovf",   32'(fifo_ovf),  32'd0);
      check("rst_busy",  32'(busy),      32'd0);
      rst = 1'b0;
      tick(5);

      // 1: single 0x1C frame with latency check relative to the stop strobe
      push_exp(1'b0, 1'b0, 8'h1C);
      ps2_bit(1'b0, 1'b0);
      for (int i = 0; i < 8; i++) ps2_bit(logic'((8'h1C >> i) & 8'h01), 1'b0);
      ps2_bit(1'b0, 1'b0);
      ps2_data = 1'b1;
      tick(int'(HALF));
      check("t1_busy_mid", 32'(busy), 32'd1);
      ps2_clk = 1'b0;
      for (b = 0; b < 40 && busy; b++) tick(1);
      check("t1_busy_drop", 32'(busy), 32'd0);
      check("t1_valid_n1", 32'(evt_valid), 32'd0);
      tick(1);
      check("t1_valid_n2", 32'(evt_valid), 32'd1);
      check("t1_code", 32'(evt_code), 32'h1C);
      tick(int'(HALF));
      ps2_clk = 1'b1;
      tick(int'(HALF));
      check("t1_nevt", 32'(n_evt), 32'd1);

      // 2: prefixes fold into events
      send_frame(8'hF0, 1'b0, 1'b1, -1);
      push_exp(1'b0, 1'b1, 8'h1C);
      send_frame(8'h1C, 1'b0, 1'b1, -1);
      send_frame(8'hE0, 1'b0, 1'b1, -1);
      send_frame(8'hF0, 1'b0, 1'b1, -1);
      push_exp(1'b1, 1'b1, 8'h75);
      send_frame(8'h75, 1'b0, 1'b1, -1);
      drain(20);
      check("t2_nevt", 32'(n_evt), 32'd3);

      // 3: parity error discards the frame
      send_frame(8'h1C, 1'b1, 1'b1, -1);
      check("t3_perr", 32'(n_par), 32'd1);
      check("t3_noevt", 32'(n_evt), 32'd3);
      push_exp(1'b0, 1'b0, 8'h29);
      send_frame(8'h29, 1'b0, 1'b1, -1);
      drain(20);

      // 4: timeout inside a frame, then a clean frame
      ps2_bit(1'b0, 1'b0);
      for (int i = 0; i < 3; i++) ps2_bit(1'b1, 1'b0);
      check("t4_busy_in", 32'(busy), 32'd1);
      tick(int'(TMO) + 50);
      check("t4_ferr", 32'(n_frm), 32'd1);
      check("t4_busy_out", 32'(busy), 32'd0);
      push_exp(1'b0, 1'b0, 8'h29);
      send_frame(8'h29, 1'b0, 1'b1, -1);
      drain(20);

      // 4b: bad stop bit
      send_frame(8'h33, 1'b0, 1'b0, -1);
      check("t4b_ferr", 32'(n_frm), 32'd2);
      check("t4b_noevt", 32'(n_evt), 32'd5);

      // 5: overflow with consumer stalled
      evt_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         if (i < 4) push_exp(1'b0, 1'b0, 8'(8'h15 + i));
         send_frame(8'(8'h15 + i), 1'b0, 1'b1, -1);
      end
      tick(5);
      check("t5_ovf", 32'(n_ovf), 32'd1);
      check("t5_valid", 32'(evt_valid), 32'd1);
      check("t5_head", 32'(evt_code), 32'h15);
      tick(3);
      check("t5_hold", 32'(evt_code), 32'h15);
      evt_ready = 1'b1;
      drain(30);
      tick(1);
      check("t5_empty", 32'(evt_valid), 32'd0);

      // 6: glitch mid-frame is ignored; reset mid-frame clears prefix and partial frame
      push_exp(1'b0, 1'b0, 8'h1C);
      send_frame(8'h1C, 1'b0, 1'b1, 3);
      drain(20);
      send_frame(8'hE0, 1'b0, 1'b1, -1);
      ps2_bit(1'b0, 1'b0);
      for (int i = 0; i < 4; i++) ps2_bit(1'b1, 1'b0);
      rst = 1'b1;
      tick(3);
      check("t6_rst_busy", 32'(busy), 32'd0);
      check("t6_rst_valid", 32'(evt_valid), 32'd0);
      rst = 1'b0;
      tick(5);
      push_exp(1'b0, 1'b0, 8'h29);
      send_frame(8'h29, 1'b0, 1'b1, -1);
      drain(20);

      check("final_perr", 32'(n_par), 32'd1);
      check("final_ferr", 32'(n_frm), 32'd2);
      check("final_ovf",  32'(n_ovf), 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
